parallel_fir_scheduler: RTL

// Sequencer in front of and behind three_parallel_pipeline (3-lane FIR).
// - Input side: accepts a serial 16-bit sample stream (valid/ready) and packs it into 3-sample blocks.
// - Issues each block to the FIR lanes together with a clock-enable strobe.
// - Output side: tracks the pipeline latency and captures the three 64-bit results of each block.

---
 rtl/parallel_fir_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/parallel_fir_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : parallel_fir_scheduler
// Brief    : Packs a serial sample stream into 3-sample blocks for a 3-lane FIR,
//            tracks FIR latency and re-serializes the lane results in order.
// Revision : 1.0 - initial release
// ============================================================================
module parallel_fir_scheduler #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 64,
    parameter int PIPE_LAT   = 3,
    parameter int OUT_BLOCKS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              flush,
    output logic [DATA_W-1:0] fir_din0,
    output logic [DATA_W-1:0] fir_din1,
    output logic [DATA_W-1:0] fir_din2,
    output logic              fir_ce,
    input  logic [ACC_W-1:0]  fir_dout0,
    input  logic [ACC_W-1:0]  fir_dout1,
    input  logic [ACC_W-1:0]  fir_dout2,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic [15:0]       blocks_issued
);

    localparam int c_PTR_W = (OUT_BLOCKS > 1) ? $clog2(OUT_BLOCKS) : 1;
    localparam int c_CNT_W = $clog2(OUT_BLOCKS + 1);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(OUT_BLOCKS - 1);

    logic [1:0]          r_fill;
    logic [DATA_W-1:0]   r_slot [0:2];
    logic                r_pad_pend;
    logic                r_s_ready;
    logic                r_fir_ce;
    logic [DATA_W-1:0]   r_din [0:2];
    logic [PIPE_LAT-1:0] r_tok;
    logic                r_cap_pend;
    logic [3*ACC_W-1:0]  r_mem [0:OUT_BLOCKS-1];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [1:0]          r_lane;
    logic [15:0]         r_blocks_issued;

    logic                w_accept;
    logic [1:0]          w_fill_acc;
    logic                w_pad_set;
    logic [c_CNT_W:0]    w_occ;
    logic                w_space;
    logic                w_issue;
    logic [1:0]          w_fill_next;
    logic                w_pad_next;
    logic [PIPE_LAT-1:0] w_tok_next;
    logic                w_m_valid;
    logic                w_m_fire;
    logic                w_pop;
    logic [3*ACC_W-1:0]  w_head;
    logic [ACC_W-1:0]    w_lane_data;

    assign w_accept   = s_valid & r_s_ready;
    assign w_fill_acc = r_fill + {1'b0, w_accept};
    // The sample arriving with flush is stored first; a full block needs no pad.
    assign w_pad_set  = flush & ((w_fill_acc == 2'd1) | (w_fill_acc == 2'd2));

    // A pending capture already owns a FIFO slot, so count it against space.
    assign w_occ   = (c_CNT_W + 1)'(r_count) + (c_CNT_W + 1)'(r_cap_pend);
    assign w_space = w_occ < (c_CNT_W + 1)'(OUT_BLOCKS);
    assign w_issue = ((r_fill == 2'd3) | r_pad_pend) & w_space;

    assign w_fill_next = w_issue ? 2'd0 : w_fill_acc;
    assign w_pad_next  = w_issue ? 1'b0 : (r_pad_pend | w_pad_set);

    // Bit k set: FIR stage k+1 holds a real block; the top stage drives fir_dout.
    assign w_tok_next = (r_tok << 1) | PIPE_LAT'(1);

    assign w_m_valid = (r_count != '0);
    assign w_m_fire  = w_m_valid & m_ready;
    assign w_pop     = w_m_fire & (r_lane == 2'd2);

    always_comb begin
        w_head      = r_mem[r_rd_ptr];
        w_lane_data = '0;
        case (r_lane)
            2'd0:    w_lane_data = w_head[ACC_W-1:0];
            2'd1:    w_lane_data = w_head[2*ACC_W-1:ACC_W];
            default: w_lane_data = w_head[3*ACC_W-1:2*ACC_W];
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_accept && (r_fill == 2'(i))) begin
                r_slot[i] <= s_data;
            end
        end
        if (r_cap_pend) begin
            r_mem[r_wr_ptr] <= {fir_dout2, fir_dout1, fir_dout0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fill          <= 2'd0;
            r_pad_pend      <= 1'b0;
            r_s_ready       <= 1'b0;
            r_fir_ce        <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_din[i] <= '0;
            end
            r_tok           <= '0;
            r_cap_pend      <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_lane          <= 2'd0;
            r_blocks_issued <= 16'd0;
        end else begin
            r_fill     <= w_fill_next;
            r_pad_pend <= w_pad_next;
            r_s_ready  <= (w_fill_next != 2'd3) & ~w_pad_next;
            r_fir_ce   <= w_issue;

            if (w_issue) begin
                // Slots beyond the fill level are the zero pad of a flushed block.
                for (int i = 0; i < 3; i++) begin
                    r_din[i] <= (2'(i) < r_fill) ? r_slot[i] : '0;
                end
                r_blocks_issued <= r_blocks_issued + 16'd1;
            end

            if (r_fir_ce) begin
                r_tok      <= w_tok_next;
                r_cap_pend <= w_tok_next[PIPE_LAT-1];
            end else begin
                r_cap_pend <= 1'b0;
            end

            if (r_cap_pend) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_m_fire) begin
                r_lane <= (r_lane == 2'd2) ? 2'd0 : r_lane + 2'd1;
            end

            case ({r_cap_pend, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign s_ready       = r_s_ready;
    assign fir_ce        = r_fir_ce;
    assign fir_din0      = r_din[0];
    assign fir_din1      = r_din[1];
    assign fir_din2      = r_din[2];
    assign m_valid       = w_m_valid;
    assign m_data        = w_m_valid ? w_lane_data : '0;
    assign blocks_issued = r_blocks_issued;

endmodule
`default_nettype wire
